uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters. Arbitration is frame-granular: a requester keeps ownership from its first byte until the byte it marks `req_last`. Each accepted byte is launched on the transmitter with a one-cycle `tx_start`, and the arbiter waits for the transmitter's busy/idle cycle before taking the next byte. A stall timeout revokes ownership from a requester that stops supplying bytes mid-frame.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART transmitter bundle for uart_tx_arbiter.
// slave = arbiter side, master = requesters plus transmitter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [OW-1:0]        owner;
  logic                 owner_valid;
  logic                 frame_abort;

  modport master (
    output req_valid, req_last, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, owner, owner_valid, frame_abort
  );

  modport slave (
    input  req_valid, req_last, req_data, tx_busy,
    output req_ready, tx_start, tx_data, owner, owner_valid, frame_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART transmitter.
// Each accepted byte is launched once and the busy/idle cycle is awaited.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {ARB, GRANT, LAUNCH, WAIT_HI, WAIT_LO} state_t;

  state_t                   state, state_d;
  logic [OW-1:0]            ptr, owner, owner_inc, win, cand;
  logic [OW:0]              sum;
  logic                     win_ok, accept, timeout, release_f;
  logic [IW-1:0]            idle_cnt;
  logic                     last_q, owner_valid, tx_start, frame_abort;
  logic [7:0]               tx_data;
  logic [NUM_REQ-1:0][7:0]  req_bytes;

  assign req_bytes = bus.req_data;
  assign owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Scan from ptr upward with explicit modulo wrap, first valid wins.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = {1'b0, ptr} + (OW+1)'(k);
      cand = (sum >= (OW+1)'(NUM_REQ)) ? OW'(sum - (OW+1)'(NUM_REQ)) : OW'(sum);
      if (!win_ok && bus.req_valid[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ARB;
    else       state <= state_d;

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    timeout   = 1'b0;
    release_f = 1'b0;
    unique case (state)
      ARB:     if (win_ok) state_d = GRANT;
      GRANT: begin
        if (bus.req_valid[owner]) begin
          accept  = 1'b1;
          state_d = LAUNCH;
        end else if (TIMEOUT != 0 && int'(idle_cnt) + 1 >= TIMEOUT) begin
          timeout = 1'b1;
          state_d = ARB;
        end
      end
      LAUNCH:  state_d = WAIT_HI;
      WAIT_HI: if (bus.tx_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            release_f = 1'b1;
            state_d   = ARB;
          end else begin
            state_d   = GRANT;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      tx_start    <= 1'b0;
      frame_abort <= 1'b0;
      tx_data     <= 8'h00;
      last_q      <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      tx_start    <= accept;
      frame_abort <= timeout;
      if (state == ARB && win_ok) begin
        owner       <= win;
        owner_valid <= 1'b1;
      end
      if (accept) begin
        tx_data <= req_bytes[owner];
        last_q  <= bus.req_last[owner];
      end
      if (timeout || release_f) begin
        ptr         <= owner_inc;
        owner_valid <= 1'b0;
      end
      // Cleared outside GRANT so every entry starts a fresh idle count.
      if (state != GRANT)
        idle_cnt <= '0;
      else if (!accept && idle_cnt != '1)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == GRANT) bus.req_ready[owner] = 1'b1;
  end

  assign bus.tx_start    = tx_start;
  assign bus.tx_data     = tx_data;
  assign bus.owner       = owner;
  assign bus.owner_valid = owner_valid;
  assign bus.frame_abort = frame_abort;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner sequences, randomized
// frames against a round-robin reference, and a 3-requester instance.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(3)) b3 ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut  (.clk(clk), .rstn(rstn), .bus(bus));
  uart_tx_arbiter #(.NUM_REQ(3), .TIMEOUT(TO)) dut3 (.clk(clk), .rstn(rstn), .bus(b3));

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Directed and random requester drives, muxed onto the bus.
  logic [N-1:0]       tv_valid = '0, tv_last = '0;
  logic [N-1:0][7:0]  tv_data  = '0;
  logic [N-1:0]       rv_valid, rv_last;
  logic [N-1:0][7:0]  rv_data;
  logic               rnd_en = 1'b0;

  assign bus.req_valid = rnd_en ? rv_valid : tv_valid;
  assign bus.req_last  = rnd_en ? rv_last  : tv_last;
  assign bus.req_data  = rnd_en ? rv_data  : tv_data;

  // Transmitter models: busy rises after tx_start and holds busy_len cycles.
  int   busy_len = 4;
  int   bcnt = 0, bcnt3 = 0;
  logic busy = 1'b0, busy3 = 1'b0;
  assign bus.tx_busy = busy;
  assign b3.tx_busy  = busy3;

  logic       en3 = 1'b0;
  logic [7:0] d3  = 8'h40;
  assign b3.req_valid = en3 ? 3'b100 : 3'b000;
  assign b3.req_last  = 3'b111;
  assign b3.req_data  = {d3, 16'h0000};

  // Launch log for both instances.
  int         nstart = 0, nabort = 0, n3 = 0;
  logic [7:0] log_d  [1024];
  logic [1:0] log_o  [1024];
  logic [7:0] log3_d [64];
  logic [1:0] log3_o [64];

  always @(negedge clk) begin
    if (bus.tx_start) begin
      log_d[nstart % 1024] = bus.tx_data;
      log_o[nstart % 1024] = bus.owner;
      nstart++;
      bcnt = busy_len;
      busy = 1'b1;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) busy = 1'b0;
    end
    if (bus.frame_abort) nabort++;
    if (b3.tx_start) begin
      log3_d[n3 % 64] = b3.tx_data;
      log3_o[n3 % 64] = b3.owner;
      n3++;
      bcnt3 = 3;
      busy3 = 1'b1;
    end else if (bcnt3 > 0) begin
      bcnt3--;
      if (bcnt3 == 0) busy3 = 1'b0;
    end
    if (!en3) d3 = 8'h40;
    else if (b3.tx_start) d3 = d3 + 8'h01;
  end

  // Random requesters: preloaded frames, random short gaps inside a frame.
  logic [7:0]   rdat  [N][16];
  logic         rlast [N][16];
  int           rlen  [N];
  int           rpos  [N];
  int           gap   [N];
  logic [N-1:0] acc_q;

  always @(negedge clk) begin
    if (!rnd_en) begin
      rv_valid = '0; rv_last = '0; rv_data = '0; acc_q = '0;
      for (int i = 0; i < N; i++) begin rpos[i] = 0; gap[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (acc_q[i]) begin
          if (!rlast[i][rpos[i] % 16]) gap[i] = $urandom_range(0, 3);
          rpos[i]++;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
        rv_valid[i] = (rpos[i] < rlen[i]) && (gap[i] == 0);
        rv_last[i]  = rlast[i][rpos[i] % 16];
        rv_data[i]  = rdat[i][rpos[i] % 16];
      end
      acc_q = bus.req_ready & rv_valid;
    end
  end

  task automatic wait_ov0(input string nm);
    for (int c = 0; c < 200 && bus.owner_valid; c++) @(negedge clk);
    check(nm, bus.owner_valid, 0);
  endtask

  task automatic wait_ready(input string nm);
    for (int c = 0; c < 200 && bus.req_ready == '0; c++) @(negedge clk);
    check(nm, bus.req_ready != '0, 1);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [7:0]   data;
    logic [1:0]   exp_owner;
  } vec_t;

  vec_t vt [11];

  // Reference model state for the random phase.
  int         fcnt [N];
  int         flen [N][4];
  int         fi   [N];
  int         bp   [N];
  logic [7:0] exp_d [64];
  logic [1:0] exp_o [64];
  int         exp_n, base, n0, na0, idle, p, j;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // ptr walk: 0->3->0->2->0->1->3->2->1->0->2->1
    vt[0]  = '{4'b0100, 8'hA5, 2'd2};
    vt[1]  = '{4'b1010, 8'h10, 2'd3};
    vt[2]  = '{4'b0110, 8'h21, 2'd1};
    vt[3]  = '{4'b1011, 8'h32, 2'd3};
    vt[4]  = '{4'b1111, 8'h43, 2'd0};
    vt[5]  = '{4'b0101, 8'h54, 2'd2};
    vt[6]  = '{4'b0110, 8'h65, 2'd1};
    vt[7]  = '{4'b0011, 8'h76, 2'd0};
    vt[8]  = '{4'b1000, 8'h87, 2'd3};
    vt[9]  = '{4'b0010, 8'h98, 2'd1};
    vt[10] = '{4'b0001, 8'hA9, 2'd0};

    repeat (2) @(negedge clk);
    check("rst_owner_valid", bus.owner_valid, 0);
    check("rst_tx_start",    bus.tx_start,    0);
    check("rst_tx_data",     bus.tx_data,     0);
    check("rst_req_ready",   bus.req_ready,   0);
    check("rst_owner",       bus.owner,       0);
    check("rst_frame_abort", bus.frame_abort, 0);
    rstn = 1'b1;

    // Single-byte frames from the table, exact latency checks.
    tv_last = '1;
    foreach (vt[v]) begin
      @(negedge clk);
      tv_valid = vt[v].mask;
      for (int i = 0; i < N; i++) tv_data[i] = vt[v].data;
      @(negedge clk);
      check("vec_owner",       bus.owner,       vt[v].exp_owner);
      check("vec_owner_valid", bus.owner_valid, 1);
      check("vec_ready",       bus.req_ready,   32'(1) << vt[v].exp_owner);
      check("vec_no_start",    bus.tx_start,    0);
      @(negedge clk);
      check("vec_tx_start",    bus.tx_start,    1);
      check("vec_tx_data",     bus.tx_data,     vt[v].data);
      check("vec_ready_drop",  bus.req_ready,   0);
      tv_valid = '0;
      wait_ov0("vec_release");
    end

    // Requester 1 sends 11,22,33 while requester 0 holds its byte.
    n0 = nstart;
    tv_valid = 4'b0011;
    tv_last  = 4'b0001;
    tv_data[0] = 8'h77;
    for (int b = 0; b < 3; b++) begin
      tv_data[1] = 8'h11 * 8'(b + 1);
      tv_last[1] = (b == 2);
      wait_ready("mb_grant_wait");
      check("mb_ready", bus.req_ready, 4'b0010);
      @(negedge clk);
    end
    wait_ready("mb_handover_wait");
    check("mb_handover", bus.req_ready, 4'b0001);
    check("mb_starts",   nstart - n0,   3);
    for (int b = 0; b < 3; b++) check("mb_bytes", log_d[(n0 + b) % 1024], 8'h11 * 8'(b + 1));
    @(negedge clk);
    tv_valid = '0;
    wait_ov0("mb_release");

    // Timeout: requester 3 stalls after one non-last byte.
    na0 = nabort;
    tv_valid = 4'b1000;
    tv_last  = '0;
    tv_data[3] = 8'h3C;
    wait_ready("to_grant_wait");
    @(negedge clk);
    tv_valid = '0;
    wait_ready("to_regrant_wait");
    idle = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.frame_abort) break;
      if (bus.req_ready == 4'b1000) idle++;
      @(negedge clk);
    end
    check("to_idle_cycles", idle,            TO);
    check("to_abort",       bus.frame_abort, 1);
    check("to_owner_valid", bus.owner_valid, 0);
    @(negedge clk);
    check("to_abort_pulse", bus.frame_abort, 0);
    check("to_abort_count", nabort - na0,    1);
    tv_valid = 4'b1001;
    tv_last  = 4'b1001;
    tv_data[0] = 8'hC0;
    tv_data[3] = 8'hC3;
    @(negedge clk);
    check("to_wrap_owner", bus.owner,     0);
    check("to_wrap_ready", bus.req_ready, 4'b0001);
    @(negedge clk);
    check("to_wrap_data",  bus.tx_data,   8'hC0);
    tv_valid = '0;
    wait_ov0("to_wrap_release");

    // Reset while the arbiter waits for the transmitter to go idle.
    tv_valid = 4'b0010;
    tv_last  = '0;
    tv_data[1] = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    check("rs_launch", bus.tx_start, 1);
    @(negedge clk);
    @(negedge clk);
    check("rs_busy_hi",   busy,            1);
    check("rs_in_frame",  bus.owner_valid, 1);
    n0 = nstart;
    rstn = 1'b0;
    #1;
    check("rs_tx_start",    bus.tx_start,    0);
    check("rs_owner_valid", bus.owner_valid, 0);
    check("rs_req_ready",   bus.req_ready,   0);
    tv_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    tv_valid = 4'b0010;
    tv_last  = 4'b0010;
    tv_data[1] = 8'h6B;
    @(negedge clk);
    check("rs_new_owner", bus.owner,     1);
    check("rs_new_ready", bus.req_ready, 4'b0010);
    @(negedge clk);
    check("rs_new_data",  bus.tx_data,   8'h6B);
    tv_valid = '0;
    wait_ov0("rs_release");
    check("rs_no_reissue", nstart - n0, 1);

    // Randomized frames against a round-robin reference.
    for (int r = 0; r < 3; r++) begin
      rstn = 1'b0;
      busy_len = $urandom_range(2, 5);
      for (int i = 0; i < N; i++) begin
        int pos;
        pos = 0;
        fcnt[i] = $urandom_range(1, 3);
        for (int f = 0; f < fcnt[i]; f++) begin
          flen[i][f] = $urandom_range(1, 3);
          for (int b = 0; b < flen[i][f]; b++) begin
            rdat[i][pos]  = 8'($urandom_range(0, 255));
            rlast[i][pos] = (b == flen[i][f] - 1);
            pos++;
          end
        end
        rlen[i] = pos;
        fi[i] = 0;
        bp[i] = 0;
      end
      p = 0;
      exp_n = 0;
      forever begin
        j = -1;
        for (int k = 0; k < N; k++)
          if (j < 0 && fi[(p + k) % N] < fcnt[(p + k) % N]) j = (p + k) % N;
        if (j < 0) break;
        for (int b = 0; b < flen[j][fi[j]]; b++) begin
          exp_d[exp_n] = rdat[j][bp[j]];
          exp_o[exp_n] = 2'(j);
          exp_n++;
          bp[j]++;
        end
        fi[j]++;
        p = (j + 1) % N;
      end
      @(negedge clk);
      rstn = 1'b1;
      base = nstart;
      na0  = nabort;
      rnd_en = 1'b1;
      for (int c = 0; c < 3000 && nstart - base < exp_n; c++) @(negedge clk);
      rnd_en = 1'b0;
      wait_ov0("rnd_release");
      check("rnd_count",  nstart - base, exp_n);
      check("rnd_aborts", nabort - na0,  0);
      for (int k = 0; k < exp_n; k++)
        check("rnd_byte", {log_o[(base + k) % 1024], log_d[(base + k) % 1024]},
              {exp_o[k], exp_d[k]});
    end

    // NUM_REQ=3: lone requester 2 must be re-granted across the ptr wrap.
    base = n3;
    en3 = 1'b1;
    for (int c = 0; c < 500 && n3 - base < 5; c++) @(negedge clk);
    en3 = 1'b0;
    check("n3_count", n3 - base >= 5, 1);
    for (int k = 0; k < 5; k++)
      check("n3_byte", {log3_o[(base + k) % 64], log3_d[(base + k) % 64]},
            {2'd2, 8'h40 + 8'(k)});

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
